// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: mode/edit controller for the electric clock.
// Turns debounced key-press flags into a mode state machine, field selection and
// single-cycle adjust strobes, drives the countdown run/clear controls, and selects
// and blinks the 32-bit word shown on the 8-digit hex8 display.
//
// Ports:
//   Clk, Reset_n      clock, asynchronous active-low reset
//   Key_P_flag[3:0]   one-cycle press flags: [3]=mode [2]=field [1]=up/start [0]=down/clear
//   Tick_1s           one-cycle pulse when the time counter advances
//   Clock_data, Calendar_data, Alarm_data, Count_data   display source words
//   Mode              current mode (0 CLOCK .. 5 COUNTDOWN)
//   Edit_field        selected field: 0=[31:24], 1=[19:12], 2=[7:0]
//   Adj_inc, Adj_dec  one-cycle adjust strobes for the selected field
//   Adj_target        strobe target: 0=clock, 1=calendar, 2=alarm
//   Cd_run, Cd_clear  countdown run level and clear strobe
//   Disp_Data         registered word to hex8
module clock_mode_ctrl #(
    parameter int unsigned BLINK_HALF = 25_000_000 - 1,
    parameter logic [3:0]  BLANK      = 4'hF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [3:0]  Key_P_flag,
    input  logic        Tick_1s,
    input  logic [31:0] Clock_data,
    input  logic [31:0] Calendar_data,
    input  logic [31:0] Alarm_data,
    input  logic [31:0] Count_data,
    output logic [2:0]  Mode,
    output logic [1:0]  Edit_field,
    output logic        Adj_inc,
    output logic        Adj_dec,
    output logic [1:0]  Adj_target,
    output logic        Cd_run,
    output logic        Cd_clear,
    output logic [31:0] Disp_Data
);

    localparam int unsigned CntW = (BLINK_HALF > 0) ? $clog2(BLINK_HALF + 1) : 1;

    typedef enum logic [2:0] {
        ModeClock     = 3'd0,
        ModeClockSet  = 3'd1,
        ModeCal       = 3'd2,
        ModeCalSet    = 3'd3,
        ModeAlarmSet  = 3'd4,
        ModeCountdown = 3'd5
    } mode_e;

    mode_e            mode_q, mode_d, mode_nxt;
    logic [1:0]       edit_field_q, edit_field_d;
    logic             pend_q, pend_d;
    logic             pend_inc_q, pend_inc_d;
    logic [1:0]       adj_target_q;
    logic             cd_run_q, cd_run_d;
    logic             cd_clear_q, cd_clear_d;
    logic [CntW-1:0]  blink_cnt_q, blink_cnt_d;
    logic             blink_blank_q, blink_blank_d;
    logic [31:0]      disp_q, disp_d;

    logic key3, key2, key1, key0;
    logic set_mode, mode_chg, issue;

    // Only the highest-priority flag acts.
    assign key3 = Key_P_flag[3];
    assign key2 = Key_P_flag[2] & ~Key_P_flag[3];
    assign key1 = Key_P_flag[1] & ~|Key_P_flag[3:2];
    assign key0 = Key_P_flag[0] & ~|Key_P_flag[3:1];

    assign set_mode = (mode_q == ModeClockSet) || (mode_q == ModeCalSet) ||
                      (mode_q == ModeAlarmSet);

    // A pending request goes out on the first cycle the time counter is not ticking,
    // so the adjust never collides with a carry from Tick_1s.
    assign issue   = pend_q & ~Tick_1s;
    assign Adj_inc = issue & pend_inc_q;
    assign Adj_dec = issue & ~pend_inc_q;

    always_comb begin
        Adj_target = adj_target_q;
        case (mode_q)
            ModeClockSet: Adj_target = 2'd0;
            ModeCalSet:   Adj_target = 2'd1;
            ModeAlarmSet: Adj_target = 2'd2;
            default:      Adj_target = adj_target_q;
        endcase
    end

    always_comb begin
        case (mode_q)
            ModeClock:    mode_nxt = ModeClockSet;
            ModeClockSet: mode_nxt = ModeCal;
            ModeCal:      mode_nxt = ModeCalSet;
            ModeCalSet:   mode_nxt = ModeAlarmSet;
            ModeAlarmSet: mode_nxt = ModeCountdown;
            default:      mode_nxt = ModeClock;  // also recovers illegal codes 6/7
        endcase
    end

    assign mode_chg = key3 | (mode_q > ModeCountdown);

    always_comb begin
        mode_d       = mode_q;
        edit_field_d = edit_field_q;
        pend_d       = pend_q & ~issue;
        pend_inc_d   = pend_inc_q;
        cd_run_d     = cd_run_q;
        cd_clear_d   = 1'b0;
        if (blink_cnt_q == CntW'(BLINK_HALF)) begin
            blink_cnt_d   = '0;
            blink_blank_d = ~blink_blank_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + CntW'(1);
            blink_blank_d = blink_blank_q;
        end

        if (mode_chg) begin
            mode_d        = mode_nxt;
            edit_field_d  = 2'd0;
            pend_d        = 1'b0;
            blink_cnt_d   = '0;
            blink_blank_d = 1'b0;
        end else begin
            if (set_mode) begin
                if (key2) begin
                    edit_field_d  = (edit_field_q == 2'd2) ? 2'd0 : edit_field_q + 2'd1;
                    blink_cnt_d   = '0;
                    blink_blank_d = 1'b0;
                end else if ((key1 | key0) && !pend_q) begin
                    pend_d     = 1'b1;
                    pend_inc_d = key1;
                end
            end
            if (mode_q == ModeCountdown) begin
                if (key1) begin
                    cd_run_d = ~cd_run_q;
                end else if (key0) begin
                    cd_clear_d = 1'b1;
                    cd_run_d   = 1'b0;
                end
            end
            // Keep the field just edited visible.
            if (issue) begin
                blink_cnt_d   = '0;
                blink_blank_d = 1'b0;
            end
        end
    end

    always_comb begin
        case (mode_q)
            ModeClock, ModeClockSet: disp_d = Clock_data;
            ModeCal, ModeCalSet:     disp_d = Calendar_data;
            ModeAlarmSet:            disp_d = Alarm_data;
            default:                 disp_d = Count_data;
        endcase
        if (set_mode && blink_blank_q) begin
            case (edit_field_q)
                2'd0:    disp_d[31:24] = {BLANK, BLANK};
                2'd1:    disp_d[19:12] = {BLANK, BLANK};
                2'd2:    disp_d[7:0]   = {BLANK, BLANK};
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_q        <= ModeClock;
            edit_field_q  <= 2'd0;
            pend_q        <= 1'b0;
            pend_inc_q    <= 1'b0;
            adj_target_q  <= 2'd0;
            cd_run_q      <= 1'b0;
            cd_clear_q    <= 1'b0;
            blink_cnt_q   <= '0;
            blink_blank_q <= 1'b0;
            disp_q        <= 32'd0;
        end else begin
            mode_q        <= mode_d;
            edit_field_q  <= edit_field_d;
            pend_q        <= pend_d;
            pend_inc_q    <= pend_inc_d;
            adj_target_q  <= Adj_target;
            cd_run_q      <= cd_run_d;
            cd_clear_q    <= cd_clear_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_blank_q <= blink_blank_d;
            disp_q        <= disp_d;
        end
    end

    assign Mode       = mode_q;
    assign Edit_field = edit_field_q;
    assign Cd_run     = cd_run_q;
    assign Cd_clear   = cd_clear_q;
    assign Disp_Data  = disp_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Randomised scoreboard bench for clock_mode_ctrl with a short blink period.
module tb_clock_mode_ctrl;

    localparam int unsigned BH       = 3;
    localparam logic [3:0]  BlankNib = 4'hF;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [3:0]  Key_P_flag = 4'd0;
    logic        Tick_1s = 1'b0;
    logic [31:0] Clock_data = 32'd0, Calendar_data = 32'd0, Alarm_data = 32'd0;
    logic [31:0] Count_data = 32'd0;
    logic [2:0]  Mode;
    logic [1:0]  Edit_field;
    logic        Adj_inc, Adj_dec;
    logic [1:0]  Adj_target;
    logic        Cd_run, Cd_clear;
    logic [31:0] Disp_Data;

    clock_mode_ctrl #(.BLINK_HALF(BH), .BLANK(BlankNib)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Key_P_flag(Key_P_flag), .Tick_1s(Tick_1s),
        .Clock_data(Clock_data), .Calendar_data(Calendar_data), .Alarm_data(Alarm_data),
        .Count_data(Count_data), .Mode(Mode), .Edit_field(Edit_field), .Adj_inc(Adj_inc),
        .Adj_dec(Adj_dec), .Adj_target(Adj_target), .Cd_run(Cd_run), .Cd_clear(Cd_clear),
        .Disp_Data(Disp_Data)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0]  mode;
        logic [1:0]  field;
        logic        inc;
        logic        dec;
        logic [1:0]  tgt;
        logic        run;
        logic        clr;
        logic [31:0] disp;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model state (plain integers and a request queue).
    int          m_mode, m_field, m_tgt, m_cnt;
    bit          m_blank, m_run, m_clr;
    bit          m_pend[$];    // 1 = increment, 0 = decrement; at most one entry
    logic [31:0] m_disp;

    function automatic obs_t sample();
        obs_t o;
        o = '{mode: Mode, field: Edit_field, inc: Adj_inc, dec: Adj_dec, tgt: Adj_target,
              run: Cd_run, clr: Cd_clear, disp: Disp_Data};
        return o;
    endfunction

    task automatic report(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got mode=%0d fld=%0d inc=%0b dec=%0b tgt=%0d run=%0b clr=%0b disp=%h required mode=%0d fld=%0d inc=%0b dec=%0b tgt=%0d run=%0b clr=%0b disp=%h",
                     name, $time, got.mode, got.field, got.inc, got.dec, got.tgt, got.run,
                     got.clr, got.disp, exp.mode, exp.field, exp.inc, exp.dec, exp.tgt,
                     exp.run, exp.clr, exp.disp);
        end
    endtask

    // Monitor: every cycle with an expectation outstanding, compare.
    always @(negedge Clk) begin
        if (exp_q.size() != 0) begin
            obs_t e;
            e = exp_q.pop_front();
            report("cycle", sample(), e);
        end
    end

    task automatic model_reset();
        m_mode = 0; m_field = 0; m_tgt = 0; m_cnt = 0;
        m_blank = 0; m_run = 0; m_clr = 0; m_disp = 32'd0;
        m_pend.delete();
    endtask

    // Apply one cycle of stimulus, push the expected observation, advance the model.
    task automatic drive(input logic [3:0] keys, input logic tick);
        obs_t        e;
        int          top, tgt, lo;
        bit          set_m, issue, had;
        logic [31:0] src, bmask;
        Key_P_flag    = keys;
        Tick_1s       = tick;
        Clock_data    = $urandom;
        Calendar_data = $urandom;
        Alarm_data    = $urandom;
        Count_data    = $urandom;

        set_m = (m_mode == 1) || (m_mode == 3) || (m_mode == 4);
        tgt   = !set_m ? m_tgt : (m_mode == 1) ? 0 : (m_mode == 3) ? 1 : 2;
        issue = (m_pend.size() != 0) && !tick;
        e.mode  = 3'(m_mode);
        e.field = 2'(m_field);
        e.inc   = issue && m_pend[0];
        e.dec   = issue && !m_pend[0];
        e.tgt   = 2'(tgt);
        e.run   = m_run;
        e.clr   = m_clr;
        e.disp  = m_disp;
        exp_q.push_back(e);

        m_tgt = tgt;
        m_clr = 0;
        if (m_mode <= 1)      src = Clock_data;
        else if (m_mode <= 3) src = Calendar_data;
        else if (m_mode == 4) src = Alarm_data;
        else                  src = Count_data;
        if (set_m && m_blank) begin
            lo    = (m_field == 0) ? 24 : (m_field == 1) ? 12 : 0;
            bmask = 32'hFF << lo;
            src   = (src & ~bmask) | ({24'd0, BlankNib, BlankNib} << lo);
        end
        m_disp = src;

        top = keys[3] ? 3 : keys[2] ? 2 : keys[1] ? 1 : keys[0] ? 0 : -1;
        if (top == 3) begin
            m_mode = (m_mode + 1) % 6;
            m_field = 0;
            m_pend.delete();
            m_cnt = 0;
            m_blank = 0;
        end else begin
            had = (m_pend.size() != 0);
            if (issue) m_pend.delete();
            if (m_cnt == BH) begin
                m_cnt = 0;
                m_blank = !m_blank;
            end else begin
                m_cnt++;
            end
            if (set_m && top == 2) begin
                m_field = (m_field + 1) % 3;
                m_cnt = 0;
                m_blank = 0;
            end
            if (set_m && (top == 1 || top == 0) && !had) m_pend.push_back(top == 1);
            if (issue) begin
                m_cnt = 0;
                m_blank = 0;
            end
            if (m_mode == 5 && top == 1) m_run = !m_run;
            if (m_mode == 5 && top == 0) begin
                m_clr = 1;
                m_run = 0;
            end
        end
        cyc++;
        @(posedge Clk);
        #1;
    endtask

    task automatic goto_mode(input int m);
        for (int i = 0; i < 8 && m_mode != m; i++) drive(4'b1000, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'd0, 1'b0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        report("reset_async", sample(), obs_t'(0));
        Key_P_flag = 4'd0;
        Tick_1s    = 1'b0;
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        report("reset_held", sample(), obs_t'(0));
        model_reset();
        Reset_n = 1'b1;
    endtask

    initial begin
        obs_t zero;
        logic [3:0] k;
        zero = '0;
        model_reset();
        @(posedge Clk);
        #1;
        do_reset();

        // Mode walk through all six modes.
        for (int i = 0; i < 6; i++) begin
            drive(4'b1000, 1'b0);
            drive(4'b0000, 1'b0);
        end
        // Field select then increment, decrement in alarm set.
        goto_mode(1);
        drive(4'b0100, 1'b0);
        drive(4'b0010, 1'b0);
        idle(2);
        goto_mode(4);
        drive(4'b0001, 1'b0);
        idle(2);
        // Tick collision with a second request during the pending cycle.
        goto_mode(1);
        drive(4'b0010, 1'b0);
        drive(4'b0010, 1'b1);
        idle(3);
        // Simultaneous flags.
        drive(4'b1010, 1'b0);
        goto_mode(3);
        drive(4'b0101, 1'b0);
        idle(2);
        // Blink on field 2 of clock set, then an increment mid-blank.
        goto_mode(1);
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b0);
        idle(10);
        drive(4'b0010, 1'b0);
        idle(6);
        // Countdown run, clear, run again, then reset while running.
        goto_mode(5);
        drive(4'b0010, 1'b0);
        idle(3);
        drive(4'b0001, 1'b0);
        idle(2);
        drive(4'b0010, 1'b0);
        drive(4'b0100, 1'b0);
        idle(2);
        do_reset();
        idle(2);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            k = 4'd0;
            if ($urandom_range(0, 4) == 0) begin
                k = 4'($urandom_range(1, 7));
                if ($urandom_range(0, 5) == 0) k[3] = 1'b1;
            end
            drive(k, ($urandom_range(0, 3) == 0));
            if (i == 2000) do_reset();
        end

        @(negedge Clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        if (zero != 0) $display("unexpected");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Central mode/edit controller for the electric clock: it turns debounced key-press flags into a mode state machine, field selection and single-cycle adjust strobes for the time, calendar and alarm counters.
- It also arbitrates which 32-bit source drives the 8-digit hex8 display and blanks the field being edited at a blink rate.
- It sits between the four key_filter instances and the counter/display blocks, replacing the ad-hoc state logic inside the top level.

Parameters:
- BLINK_HALF, 25_000_000-1, cycles per blink half-period (0.5 s at 50 MHz).
- BLANK, 4'hF, nibble value hex8 renders as an unlit digit.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous active-low reset
- Key_P_flag  in  4  one-cycle debounced press flags; [3]=mode, [2]=field, [1]=up/start, [0]=down/clear
- Tick_1s  in  1  one-cycle pulse when the time counter advances
- Clock_data  in  32  time display word {s0,s1,P,m0,m1,P,h0,h1}
- Calendar_data  in  32  date display word, same nibble layout
- Alarm_data  in  32  alarm display word, same nibble layout
- Count_data  in  32  countdown display word, same nibble layout
- Mode  out  3  current mode
- Edit_field  out  2  selected field: 0=nibbles[31:24], 1=[19:12], 2=[7:0]
- Adj_inc  out  1  one-cycle increment strobe for the selected field
- Adj_dec  out  1  one-cycle decrement strobe for the selected field
- Adj_target  out  2  target of the strobe: 0=clock, 1=calendar, 2=alarm
- Cd_run  out  1  countdown run enable (level)
- Cd_clear  out  1  one-cycle countdown clear strobe
- Disp_Data  out  32  registered word to hex8

Behaviour:
- Reset values: Mode=0, Edit_field=0, Adj_inc=0, Adj_dec=0, Adj_target=0, Cd_run=0, Cd_clear=0, Disp_Data=0, blink counter=0, blink phase=visible, pending request cleared.
- Modes:
  - 0 CLOCK, 1 CLOCK_SET, 2 CALENDAR, 3 CALENDAR_SET, 4 ALARM_SET, 5 COUNTDOWN.
  - Key3 advances the mode 0->1->2->3->4->5->0.
  - Mode codes 6 and 7 are illegal and return to 0 on the next cycle.
- Simultaneous flags in one cycle: priority is Key3 > Key2 > Key1 > Key0. Only the highest-priority flag acts; the others are dropped.
- Mode change:
  - Edit_field returns to 0, the pending request is cleared and the blink counter is reset.
  - Cd_run is kept when leaving COUNTDOWN, so the countdown continues in the background.
- Set modes (1, 3, 4):
  - Key2 cycles Edit_field 0->1->2->0.
  - Key1 requests an increment; Key0 requests a decrement.
  - Adj_target is 0 in mode 1, 1 in mode 3 and 2 in mode 4. In all other modes Adj_target holds its last value.
  - A request is issued as a one-cycle Adj_inc or Adj_dec on the cycle after the flag. Adj_inc and Adj_dec are never high together.
- Tick collision handshake:
  - If the cycle in which the strobe would be issued has Tick_1s=1, the request is held pending and issued on the first cycle with Tick_1s=0.
  - Only one pending request is held; a new Key1/Key0 flag while one is pending is dropped.
- Non-set modes 0 and 2: Key2, Key1 and Key0 are ignored.
- COUNTDOWN mode (5):
  - Key1 toggles Cd_run.
  - Key0 pulses Cd_clear for one cycle (cycle after the flag) and forces Cd_run=0 in the same cycle.
  - Key2 is ignored.
- Blink:
  - The counter counts 0..BLINK_HALF, then wraps and toggles the phase.
  - On Key2, or on any issued Adj strobe, the counter resets to 0 and the phase is forced visible, so an edited field is always seen immediately.
- Display:
  - Source selection: modes 0-1 use Clock_data, 2-3 use Calendar_data, 4 uses Alarm_data, 5 uses Count_data.
  - In set modes during the blank phase, the two nibbles of the selected field are replaced with BLANK. Point nibbles are never blanked.
  - Disp_Data is registered, so a source or mode change appears on the next cycle.
- Reset asserted mid-operation clears all state immediately, including a pending request and a running countdown.

Test Plan:
1. Reset, then Key3 pulsed 6 times -> Mode steps 1,2,3,4,5,0; Edit_field stays 0; no Adj or Cd strobes.
2. Mode=1, Key2 once, then Key1 -> Adj_inc=1 for exactly one cycle, one cycle after the flag, with Adj_target=0 and Edit_field=1. Then Key0 in mode 4 -> Adj_dec pulse with Adj_target=2.
3. Mode=1, Key1 one cycle before a Tick_1s pulse -> no strobe on the tick cycle; Adj_inc on the following cycle. A second Key1 during the pending cycle produces no extra strobe.
4. Key3 and Key1 asserted together in mode 1 -> Mode=2 and no Adj_inc. Key2 and Key0 together -> field advances and no Adj_dec.
5. BLINK_HALF=3, Mode=1, Edit_field=2, Clock_data=32'h12A34A56 -> Disp_Data alternates 32'h12A34A56 and 32'h12A34AFF every 4 cycles. A Key1 press forces the visible word immediately.
6. Mode=5: Key1 sets Cd_run=1 and Disp_Data follows Count_data. Key0 gives a Cd_clear pulse and Cd_run=0. Assert Reset_n=0 with Cd_run=1 -> all outputs return to 0 asynchronously.
